// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      FILL      = 2'd3
   } state_t;

   localparam int WORD_W     = 32;
   localparam int DEF_LINES  = 32;
   localparam int DEF_WORDS  = 8;
   localparam int DEF_ADDR_W = 32;

   localparam int OFF_W  = $clog2(DEF_WORDS);
   localparam int IDX_W  = $clog2(DEF_LINES);
   localparam int TAG_W  = DEF_ADDR_W - IDX_W - OFF_W - 2;
   localparam int LINE_W = WORD_W * DEF_WORDS;

   // Callers truncate the 64-bit results to their own field widths.
   function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int off_w);
      return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off_w, input int idx_w);
      return (addr >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_w, input int idx_w);
      return addr >> (off_w + idx_w + 2);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read by index, synchronous line fill or word update.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int LINES     = DEF_LINES,
   parameter int WORDS     = DEF_WORDS,
   parameter int IDX_BITS  = IDX_W,
   parameter int OFF_BITS  = OFF_W,
   parameter int TAG_BITS  = TAG_W,
   parameter int LINE_BITS = LINE_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_BITS-1:0]  idx,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   output logic [TAG_BITS-1:0]  rd_tag,
   output logic [LINE_BITS-1:0] rd_line,
   input  logic                 line_we,
   input  logic [TAG_BITS-1:0]  line_tag,
   input  logic [LINE_BITS-1:0] line_data,
   input  logic                 word_we,
   input  logic [OFF_BITS-1:0]  word_off,
   input  logic [WORD_W-1:0]    word_data
);

   logic [LINE_BITS-1:0] data_mem [LINES];
   logic [TAG_BITS-1:0]  tag_mem  [LINES];
   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_mem[idx];
   assign rd_line  = data_mem[idx];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_we) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Payload storage is deliberately left out of reset; valid bits guard it.
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         data_mem[idx] <= line_data;
         tag_mem[idx]  <= line_tag;
      end else if (word_we) begin
         data_mem[idx][{word_off, 5'b0} +: WORD_W] <= word_data;
      end
   end

   // WORDS is carried for interface symmetry; geometry arrives via the derived widths.
   localparam int WORDS_CHK = WORDS * WORD_W;
   if (WORDS_CHK != LINE_BITS) begin : g_bad_geometry
      $error("dcache_sram: LINE_BITS does not match WORDS");
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic, miss FSM, memory handshake.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES  = DEF_LINES,
   parameter int WORDS  = DEF_WORDS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_W-1:0]     cpu_addr_i,
   input  logic [31:0]           cpu_wdata_i,
   output logic [31:0]           cpu_rdata_o,
   output logic                  cpu_stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [32*WORDS-1:0]   mem_wdata_o,
   input  logic [32*WORDS-1:0]   mem_rdata_i,
   input  logic                  mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
`endif
);

   localparam int OFF_BITS  = $clog2(WORDS);
   localparam int IDX_BITS  = $clog2(LINES);
   localparam int TAG_BITS  = ADDR_W - IDX_BITS - OFF_BITS - 2;
   localparam int LINE_BITS = WORD_W * WORDS;

   state_t state_q, state_d;

   logic [OFF_BITS-1:0]  req_off;
   logic [IDX_BITS-1:0]  req_idx;
   logic [TAG_BITS-1:0]  req_tag;
   logic                 rd_valid, rd_dirty;
   logic [TAG_BITS-1:0]  rd_tag;
   logic [LINE_BITS-1:0] rd_line;
   logic [LINE_BITS-1:0] fill_q;
   logic                 hit, idle_hit;

   assign req_off = OFF_BITS'(addr_offset(64'(cpu_addr_i), OFF_BITS));
   assign req_idx = IDX_BITS'(addr_index(64'(cpu_addr_i), OFF_BITS, IDX_BITS));
   assign req_tag = TAG_BITS'(addr_tag(64'(cpu_addr_i), OFF_BITS, IDX_BITS));

   assign hit      = cpu_req_i & rd_valid & (rd_tag == req_tag);
   assign idle_hit = (state_q == IDLE) & hit;

   dcache_sram #(
      .LINES     (LINES),
      .WORDS     (WORDS),
      .IDX_BITS  (IDX_BITS),
      .OFF_BITS  (OFF_BITS),
      .TAG_BITS  (TAG_BITS),
      .LINE_BITS (LINE_BITS)
   ) u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx       (req_idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .line_we   ((state_q == FILL) & rst_i),
      .line_tag  (req_tag),
      .line_data (fill_q),
      .word_we   (idle_hit & cpu_we_i & rst_i),
      .word_off  (req_off),
      .word_data (cpu_wdata_i)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (state_q == ALLOCATE && mem_ack_i) fill_q <= mem_rdata_i;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (cpu_req_i && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
         ALLOCATE:  if (mem_ack_i) state_d = FILL;
         FILL:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Miss detection stalls combinationally so the pipeline never advances past a missing access.
   always_comb begin
      cpu_stall_o = 1'b0;
      cpu_rdata_o = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      unique case (state_q)
         IDLE: begin
            cpu_stall_o = cpu_req_i & ~hit;
            if (hit && !cpu_we_i) cpu_rdata_o = rd_line[{req_off, 5'b0} +: WORD_W];
         end
         WRITEBACK: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {rd_tag, req_idx, {(OFF_BITS+2){1'b0}}};
            mem_wdata_o = rd_line;
         end
         ALLOCATE: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_addr_o  = {req_tag, req_idx, {(OFF_BITS+2){1'b0}}};
         end
         FILL:    cpu_stall_o = 1'b1;
         default: cpu_stall_o = 1'b0;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic post_fill_q;

   // The hit that retires a refilled access belongs to the miss, not the hit count.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         post_fill_q <= 1'b0;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
      end else begin
         post_fill_q <= (state_q == FILL);
         if (idle_hit && !post_fill_q && hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (state_q == IDLE && cpu_req_i && !hit && miss_cnt_o != 32'hFFFF_FFFF)
            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed table, reset/handshake corner cases, random traffic vs a memory-level model.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i, cpu_we_i;
   logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o, mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o, mem_rdata_i;
   logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   dcache_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
`endif
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_stall;
      logic [31:0] exp_rdata;
      logic [31:0] wb_addr;
      logic [31:0] wb_w1;
   } vec_t;

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [255:0] data;
      bit           cont;
   } trans_t;

   trans_t      trans_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] bmem    [logic [31:0]];
   int          ack_delay = 1;
   bit          resp_on = 1'b1;
   int          rcnt = 0;
   bit          rcont = 1'b0;
   bit          was_ack;
   logic        mvalid [32];
   logic        mdirty [32];
   logic [31:0] mtag   [32];
   int          exp_hits = 0;
   int          exp_misses = 0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return 32'h1000 + (a >> 2) - 32'h40;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      logic [31:0] k;
      k = a & ~32'h3;
      return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
   endfunction

   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : dflt(a);
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Backing memory: acks after ack_delay request cycles, keeps a log of every completed transfer.
   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (resp_on) begin
            was_ack   = mem_ack_i;
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
               if (was_ack || rcnt == 0) begin
                  rcnt  = 1;
                  rcont = was_ack;
               end else begin
                  rcnt++;
               end
               if (rcnt >= ack_delay) begin
                  trans_t t;
                  t.we   = mem_we_o;
                  t.addr = mem_addr_o;
                  t.data = mem_wdata_o;
                  t.cont = rcont;
                  for (int k = 0; k < 8; k++) begin
                     if (t.we) bmem[t.addr + 32'(4*k)] = t.data[32*k +: 32];
                     else      mem_rdata_i[32*k +: 32] = bmem_rd(t.addr + 32'(4*k));
                  end
                  trans_q.push_back(t);
                  mem_ack_i = 1'b1;
               end
            end else begin
               rcnt = 0;
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
         mtag[i]   = '0;
      end
      ref_mem    = bmem;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic do_reset();
      rst_i     = 1'b0;
      cpu_req_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      model_reset();
   endtask

   // One CPU access, held until the stall clears; predicted from the memory-level model.
   task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int d, output int stalls, output logic [31:0] rdata);
      int          idx;
      logic [31:0] tag, line, vaddr;
      bit          ehit, ewb;
      int          n, exp_st;
      idx   = int'((addr >> 5) & 32'h1F);
      tag   = addr >> 10;
      line  = addr & ~32'h1F;
      ehit  = mvalid[idx] && (mtag[idx] == tag);
      ewb   = !ehit && mvalid[idx] && mdirty[idx];
      vaddr = (mtag[idx] << 10) | (32'(idx) << 5);
      ack_delay = d;
      trans_q.delete();
      cpu_req_i   = 1'b1;
      cpu_we_i    = we;
      cpu_addr_i  = addr;
      cpu_wdata_i = wdata;
      stalls = 0;
      @(negedge clk_i);
      while (cpu_stall_o !== 1'b0 && stalls < 500) begin
         stalls++;
         @(negedge clk_i);
      end
      rdata  = cpu_rdata_o;
      exp_st = ehit ? 0 : 2 + d * (ewb ? 2 : 1);
      check_output("stall_cycles", 32'(stalls), 32'(exp_st));
      if (!we) check_output("load_data", rdata, ref_rd(addr));
      check_output("mem_req_after", 32'(mem_req_o), 32'd0);
      if (!ehit) begin
         n = ewb ? 2 : 1;
         check_output("traffic_count", 32'(trans_q.size()), 32'(n));
         if (trans_q.size() == n) begin
            if (ewb) begin
               check_output("wb_we", 32'(trans_q[0].we), 32'd1);
               check_output("wb_addr", trans_q[0].addr, vaddr);
               for (int k = 0; k < 8; k++)
                  check_output("wb_word", trans_q[0].data[32*k +: 32], ref_rd(vaddr + 32'(4*k)));
               check_output("req_continuous", 32'(trans_q[1].cont), 32'd1);
            end
            check_output("rd_we", 32'(trans_q[n-1].we), 32'd0);
            check_output("rd_addr", trans_q[n-1].addr, line);
         end
         exp_misses++;
      end else begin
         exp_hits++;
      end
      if (we) ref_mem[addr & ~32'h3] = wdata;
      mdirty[idx] = ehit ? (mdirty[idx] | we) : we;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        tbl [11];
      int          st;
      logic [31:0] rd, a;

      tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0,         7, 32'h0000_1000, 32'h0,     32'h0};
      tbl[1]  = '{1'b1, 32'h0000_0104, 32'hDEADBEEF,  0, 32'h0,         32'h0,     32'h0};
      tbl[2]  = '{1'b0, 32'h0000_0104, 32'h0,         0, 32'hDEADBEEF,  32'h0,     32'h0};
      tbl[3]  = '{1'b0, 32'h0000_011C, 32'h0,         0, 32'h0000_1007, 32'h0,     32'h0};
      tbl[4]  = '{1'b0, 32'h0000_0504, 32'h0,        12, 32'h0000_1101, 32'h100,   32'hDEADBEEF};
      tbl[5]  = '{1'b0, 32'h0000_0104, 32'h0,         7, 32'hDEADBEEF,  32'h0,     32'h0};
      tbl[6]  = '{1'b1, 32'h0000_0A08, 32'hCAFEF00D,  7, 32'h0,         32'h0,     32'h0};
      tbl[7]  = '{1'b0, 32'h0000_0A08, 32'h0,         0, 32'hCAFEF00D,  32'h0,     32'h0};
      tbl[8]  = '{1'b0, 32'h0000_0A00, 32'h0,         0, 32'h0000_1240, 32'h0,     32'h0};
      tbl[9]  = '{1'b0, 32'h0000_0A1C, 32'h0,         0, 32'h0000_1247, 32'h0,     32'h0};
      tbl[10] = '{1'b0, 32'h0000_1208, 32'h0,        12, 32'h0000_1442, 32'hA00,   32'h0000_1241};

      cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
      do_reset();

      @(negedge clk_i);
      check_output("reset_stall", 32'(cpu_stall_o), 32'd0);
      check_output("reset_mem_req", 32'(mem_req_o), 32'd0);
      check_output("reset_mem_we", 32'(mem_we_o), 32'd0);
      check_output("reset_mem_addr", mem_addr_o, 32'd0);
      check_output("reset_rdata", cpu_rdata_o, 32'd0);
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 11; i++) begin
         apply_stimulus(tbl[i].we, tbl[i].addr, tbl[i].wdata, 5, st, rd);
         check_output("tbl_stall", 32'(st), 32'(tbl[i].exp_stall));
         if (!tbl[i].we) check_output("tbl_rdata", rd, tbl[i].exp_rdata);
         if (tbl[i].wb_addr != 32'h0) begin
            check_output("tbl_wb_addr", trans_q.size() > 0 ? trans_q[0].addr : 32'hFFFF_FFFF, tbl[i].wb_addr);
            check_output("tbl_wb_word1", trans_q.size() > 0 ? trans_q[0].data[63:32] : 32'hFFFF_FFFF, tbl[i].wb_w1);
         end
      end
`ifdef DCACHE_STATS_EN
      check_output("hit_cnt", hit_cnt_o, 32'(exp_hits));
      check_output("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif

      // Dirty a line, then reset in the middle of a refill: the dirty word must be lost.
      apply_stimulus(1'b1, 32'h0000_0104, 32'h1111_2222, 3, st, rd);
      ack_delay   = 20;
      cpu_req_i   = 1'b1;
      cpu_we_i    = 1'b0;
      cpu_addr_i  = 32'h0000_3000;
      repeat (3) @(negedge clk_i);
      check_output("alloc_req", 32'(mem_req_o), 32'd1);
      check_output("alloc_we", 32'(mem_we_o), 32'd0);
      check_output("alloc_addr", mem_addr_o, 32'h0000_3000);
      rst_i     = 1'b0;
      cpu_req_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check_output("req_after_reset", 32'(mem_req_o), 32'd0);
      check_output("stall_after_reset", 32'(cpu_stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      model_reset();
      apply_stimulus(1'b0, 32'h0000_3000, 32'h0, 3, st, rd);
      check_output("remiss_stall", 32'(st), 32'd5);
      check_output("remiss_rdata", rd, 32'h0000_1BC0);
      apply_stimulus(1'b0, 32'h0000_0104, 32'h0, 2, st, rd);
      check_output("lost_dirty_rdata", rd, 32'hDEADBEEF);

      // A stray ack with no outstanding request must be ignored.
      resp_on   = 1'b0;
      mem_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check_output("stray_ack_stall", 32'(cpu_stall_o), 32'd0);
         check_output("stray_ack_req", 32'(mem_req_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      resp_on   = 1'b1;
      apply_stimulus(1'b0, 32'h0000_3004, 32'h0, 2, st, rd);
      check_output("stray_ack_hit", 32'(st), 32'd0);

      for (int i = 0; i < 300; i++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2);
         apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 4)), st, rd);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk_i);
            check_output("idle_stall", 32'(cpu_stall_o), 32'd0);
            check_output("idle_rdata", cpu_rdata_o, 32'd0);
            @(posedge clk_i);
            #1;
         end
      end
`ifdef DCACHE_STATS_EN
      check_output("hit_cnt_final", hit_cnt_o, 32'(exp_hits));
      check_output("miss_cnt_final", miss_cnt_o, 32'(exp_misses));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage (EXMEM address/data/MemRead/MemWrite) and a multi-cycle line-wide backing memory.
- Hits complete combinationally in the same cycle.
- Misses raise cpu_stall_o, which freezes PC, IFID, IDEX, EXMEM and MEMWB, while an FSM writes back the victim and refills the line.
- Replaces the single-cycle Data_Memory instance at the CPU top.

Parameters:
- LINES, 32, number of cache lines (power of 2)
- WORDS, 8, 32-bit words per line (power of 2); line width LINE_W = 32*WORDS
- ADDR_W, 32, byte address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: synchronous, active-low
- cpu_req_i  in  1  access valid (EXMEM MemRead | MemWrite)
- cpu_we_i  in  1  1 = store word, 0 = load word
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data, valid when cpu_req_i & !cpu_we_i & !cpu_stall_o
- cpu_stall_o  out  1  pipeline freeze
- mem_req_o  out  1  backing-memory request, held until ack
- mem_we_o  out  1  1 = line write (writeback), 0 = line read
- mem_addr_o  out  ADDR_W  line-aligned address (offset bits zero)
- mem_wdata_o  out  LINE_W  victim line
- mem_rdata_i  in  LINE_W  refill line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - offset = addr[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Per line: valid, dirty, tag, data.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE, FILL.
- IDLE:
  - Hit read: cpu_rdata_o = selected word, same cycle, cpu_stall_o = 0.
  - Hit write: word updated and dirty set at the clock edge, cpu_stall_o = 0.
  - Miss: cpu_stall_o = 1 combinationally in the same cycle. Next state is WRITEBACK if valid & dirty, else ALLOCATE.
  - No request: stall 0, no state change.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 0}, mem_wdata_o = victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {req tag, index, 0}.
  - On mem_ack_i, capture mem_rdata_i and go to FILL.
- FILL: write the captured line into the array, set valid = 1, dirty = 0, tag = req tag. Next state is IDLE.
- cpu_stall_o = 1 in WRITEBACK, ALLOCATE and FILL. The cycle after FILL re-evaluates in IDLE as a hit: a load returns data, a store merges its word and sets dirty.
- Latency, clean miss: detect cycle + cycles to ack + FILL, then the hit cycle. A dirty miss adds the writeback handshake.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i stable while cpu_stall_o = 1. Behaviour is undefined if it does not.
- mem_ack_i is ignored while mem_req_o = 0. mem_req_o drops in the cycle after ack.
- mem_req_o remains asserted continuously across the WRITEBACK-to-ALLOCATE transition; mem_we_o changes.
- Reset values:
  - FSM = IDLE.
  - All valid and dirty bits = 0.
  - mem_req_o = 0, mem_we_o = 0, cpu_stall_o = 0.
  - mem_addr_o and cpu_rdata_o = 0 when idle with no request.
  - Data and tag arrays are not reset.
- Reset mid-miss: FSM returns to IDLE and mem_req_o drops in the next cycle. An in-flight writeback is abandoned, and its dirty data is lost by design.
- Word offset wrap: the offset only selects within the line. There is no cross-line access.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- With the macro defined:
  - Adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0], both reset to 0.
  - hit_cnt_o increments once per request completing without stall.
  - miss_cnt_o increments once per miss at the IDLE miss-detect cycle. The post-FILL hit is not counted as a hit.
  - Both counters saturate at 0xFFFF_FFFF.
- Without the macro: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Package dcache_pkg:
  - State enum (IDLE, WRITEBACK, ALLOCATE, FILL).
  - Derived widths: OFF_W, IDX_W, TAG_W, LINE_W.
  - Address-field extraction functions.
- Sub-module dcache_sram: tag/valid/dirty/data array.
  - Async read by index.
  - Synchronous write of a full line or a single word with dirty/valid update.
  - Synchronous clear of valid/dirty on rst_i low.
- dcache_ctrl holds the FSM, hit logic and memory handshake.

Test Plan:
- Reset, then load 0x0000_0100 with memory acking after 5 cycles and line data word k = 0x1000+k: stall high for 7 cycles (detect + 5 wait + FILL); next cycle rdata = 0x1000, stall 0; miss_cnt = 1.
- Store 0xDEADBEEF to 0x104, then load 0x104: both have no stall; rdata = 0xDEADBEEF; dirty set on the line at index 8.
- Load 0x0000_0504 (same index, new tag): mem write request to address 0x100 containing 0xDEADBEEF in word 1, then a read request to 0x500; mem_req stays high across the transition.
- Store miss to 0x0000_0A08 on a clean line: after the refill, word 2 = store data, dirty = 1, other words = refill data.
- Assert rst_i low during ALLOCATE: mem_req_o falls in the next cycle; after release, a load of the previous address misses again.
- Hold mem_ack_i high with no request: no state change and no stall.
